// File: rtl/hazard_scoreboard_if.sv
// Bundle of the ID-stage query, issue and writeback signals of hazard_scoreboard.
// The slave modport is the scoreboard side; master is the pipeline/driver side.
interface hazard_scoreboard_if #(
  parameter int REG_WIDTH   = 5,
  parameter int LAT_WIDTH   = 4,
  parameter int MAX_PENDING = 4
);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [REG_WIDTH-1:0] ID_Rs;
  logic [REG_WIDTH-1:0] ID_Rt;
  logic                 ID_NeedRs;
  logic                 ID_NeedRt;
  logic                 ID_Issue;
  logic [REG_WIDTH-1:0] ID_IssueDst;
  logic [LAT_WIDTH-1:0] ID_IssueLat;
  logic                 Stall_In;
  logic                 Flush;
  logic                 ID_Stall;
  logic                 ID_RsFwd;
  logic                 ID_RtFwd;
  logic                 WB_Valid;
  logic [REG_WIDTH-1:0] WB_Dst;
  logic [CNT_W-1:0]     Pending_Count;
  logic [31:0]          Stall_Count;

  modport master (
    output ID_Rs, ID_Rt, ID_NeedRs, ID_NeedRt, ID_Issue, ID_IssueDst, ID_IssueLat,
           Stall_In, Flush,
    input  ID_Stall, ID_RsFwd, ID_RtFwd, WB_Valid, WB_Dst, Pending_Count, Stall_Count
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_NeedRs, ID_NeedRt, ID_Issue, ID_IssueDst, ID_IssueLat,
           Stall_In, Flush,
    output ID_Stall, ID_RsFwd, ID_RtFwd, WB_Valid, WB_Dst, Pending_Count, Stall_Count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard for long-latency ops: operand stall/forward, WAW and writeback-port checks.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_EN.
module hazard_scoreboard #(
  parameter int REG_WIDTH   = 5,
  parameter int LAT_WIDTH   = 4,
  parameter int MAX_PENDING = 4
) (
  input  logic           clk,
  input  logic           rst,
  hazard_scoreboard_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam int IDX_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;

  logic [MAX_PENDING-1:0] r_valid;
  logic [REG_WIDTH-1:0]   r_dst [MAX_PENDING];
  logic [LAT_WIDTH-1:0]   r_cnt [MAX_PENDING];

  logic [LAT_WIDTH-1:0]   w_lat_eff;
  logic [LAT_WIDTH:0]     w_lat_p1;
  logic                   w_rs_busy, w_rs_last, w_rt_busy, w_rt_last;
  logic                   w_waw, w_port_clash;
  logic                   w_wb_valid;
  logic [REG_WIDTH-1:0]   w_wb_dst;
  logic [CNT_W-1:0]       w_pend;
  logic                   w_free_found;
  logic [IDX_W-1:0]       w_free_idx;
  logic                   w_stall_rs, w_stall_rt, w_issue_stall, w_stall, w_alloc;

  assign w_lat_eff = (bus.ID_IssueLat == '0) ? LAT_WIDTH'(1) : bus.ID_IssueLat;
  assign w_lat_p1  = {1'b0, w_lat_eff} + (LAT_WIDTH+1)'(1);

  always_comb begin
    w_rs_busy    = 1'b0;
    w_rs_last    = 1'b0;
    w_rt_busy    = 1'b0;
    w_rt_last    = 1'b0;
    w_waw        = 1'b0;
    w_port_clash = 1'b0;
    w_wb_valid   = 1'b0;
    w_wb_dst     = '0;
    w_pend       = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < MAX_PENDING; i++) begin
      if (r_valid[i]) begin
        if (bus.ID_Rs != '0 && r_dst[i] == bus.ID_Rs) begin
          if (r_cnt[i] == LAT_WIDTH'(1)) w_rs_last = 1'b1;
          else                           w_rs_busy = 1'b1;
        end
        if (bus.ID_Rt != '0 && r_dst[i] == bus.ID_Rt) begin
          if (r_cnt[i] == LAT_WIDTH'(1)) w_rt_last = 1'b1;
          else                           w_rt_busy = 1'b1;
        end
        if (bus.ID_IssueDst != '0 && r_dst[i] == bus.ID_IssueDst) w_waw = 1'b1;
        // An entry at L+1 would write back in the same cycle as the new op.
        if ({1'b0, r_cnt[i]} == w_lat_p1) w_port_clash = 1'b1;
        if (r_cnt[i] == LAT_WIDTH'(1)) begin
          w_wb_valid = 1'b1;
          w_wb_dst   = w_wb_dst | r_dst[i];
        end
        w_pend = w_pend + CNT_W'(1);
      end else if (!w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  assign w_stall_rs    = bus.ID_NeedRs & w_rs_busy;
  assign w_stall_rt    = bus.ID_NeedRt & w_rt_busy;
  assign w_issue_stall = bus.ID_Issue & ((&r_valid) | w_waw | w_port_clash);
  assign w_stall       = ~rst & (w_stall_rs | w_stall_rt | w_issue_stall);
  assign w_alloc       = bus.ID_Issue & ~w_stall & ~bus.Stall_In & ~bus.Flush &
                         (bus.ID_IssueDst != '0) & w_free_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < MAX_PENDING; i++) begin
        r_dst[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_PENDING; i++) begin
        if (r_valid[i]) begin
          if (r_cnt[i] == LAT_WIDTH'(1)) r_valid[i] <= 1'b0;
          else                           r_cnt[i]   <= r_cnt[i] - LAT_WIDTH'(1);
        end else if (w_alloc && w_free_idx == IDX_W'(i)) begin
          r_valid[i] <= 1'b1;
          r_dst[i]   <= bus.ID_IssueDst;
          r_cnt[i]   <= w_lat_eff;
        end
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != 32'hFFFFFFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign bus.Stall_Count = r_stall_cnt;
`else
  assign bus.Stall_Count = 32'd0;
`endif

  assign bus.ID_Stall      = w_stall;
  assign bus.ID_RsFwd      = ~rst & w_rs_last & ~w_stall_rs;
  assign bus.ID_RtFwd      = ~rst & w_rt_last & ~w_stall_rt;
  assign bus.WB_Valid      = ~rst & w_wb_valid;
  assign bus.WB_Dst        = rst ? '0 : w_wb_dst;
  assign bus.Pending_Count = w_pend;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic
// compared every cycle against a writeback-time model of the pending ops.
module tb_hazard_scoreboard;
  localparam int RW = 5;
  localparam int LW = 4;
  localparam int MP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_WIDTH(RW), .LAT_WIDTH(LW), .MAX_PENDING(MP)) bus ();
  hazard_scoreboard #(.REG_WIDTH(RW), .LAT_WIDTH(LW), .MAX_PENDING(MP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each pending op is a destination plus the absolute cycle of its writeback.
  int m_dst[$];
  int m_wb[$];
  int m_t = 0;
  logic [31:0] m_stall_cnt = 0;

  always @(negedge clk) begin
    bit e_stall, e_rs_fwd, e_rt_fwd, e_wbv, rs_busy, rt_busy, waw, clash;
    int e_wbd, lat, rs, rt, dst;
    if (rst) begin
      m_dst.delete();
      m_wb.delete();
      m_stall_cnt = 0;
      chk("rst_stall", {31'b0, bus.ID_Stall}, 0);
      chk("rst_rsfwd", {31'b0, bus.ID_RsFwd}, 0);
      chk("rst_rtfwd", {31'b0, bus.ID_RtFwd}, 0);
      chk("rst_wbv", {31'b0, bus.WB_Valid}, 0);
      chk("rst_wbdst", {27'b0, bus.WB_Dst}, 0);
      chk("rst_pend", {29'b0, bus.Pending_Count}, 0);
      chk("rst_stallcnt", bus.Stall_Count, 0);
    end else begin
      rs = int'(bus.ID_Rs); rt = int'(bus.ID_Rt); dst = int'(bus.ID_IssueDst);
      lat = (bus.ID_IssueLat == 0) ? 1 : int'(bus.ID_IssueLat);
      rs_busy = 0; rt_busy = 0; e_rs_fwd = 0; e_rt_fwd = 0;
      waw = 0; clash = 0; e_wbv = 0; e_wbd = 0;
      foreach (m_dst[k]) begin
        if (rs != 0 && m_dst[k] == rs) begin
          if (m_wb[k] > m_t) rs_busy = 1; else e_rs_fwd = 1;
        end
        if (rt != 0 && m_dst[k] == rt) begin
          if (m_wb[k] > m_t) rt_busy = 1; else e_rt_fwd = 1;
        end
        if (dst != 0 && m_dst[k] == dst) waw = 1;
        if (m_wb[k] == m_t + lat) clash = 1;
        if (m_wb[k] == m_t) begin e_wbv = 1; e_wbd = m_dst[k]; end
      end
      rs_busy = rs_busy & bus.ID_NeedRs;
      rt_busy = rt_busy & bus.ID_NeedRt;
      if (rs_busy) e_rs_fwd = 0;
      if (rt_busy) e_rt_fwd = 0;
      e_stall = rs_busy | rt_busy |
                (bus.ID_Issue & ((m_dst.size() == MP) | waw | clash));
      chk("id_stall", {31'b0, bus.ID_Stall}, {31'b0, e_stall});
      chk("rs_fwd", {31'b0, bus.ID_RsFwd}, {31'b0, e_rs_fwd});
      chk("rt_fwd", {31'b0, bus.ID_RtFwd}, {31'b0, e_rt_fwd});
      chk("wb_valid", {31'b0, bus.WB_Valid}, {31'b0, e_wbv});
      chk("wb_dst", {27'b0, bus.WB_Dst}, e_wbd);
      chk("pending", {29'b0, bus.Pending_Count}, m_dst.size());
`ifdef HAZARD_PERF_EN
      chk("stall_cnt", bus.Stall_Count, m_stall_cnt);
      if (e_stall && m_stall_cnt != 32'hFFFFFFFF) m_stall_cnt++;
`else
      chk("stall_cnt", bus.Stall_Count, 0);
`endif
      for (int k = m_dst.size() - 1; k >= 0; k--)
        if (m_wb[k] == m_t) begin m_dst.delete(k); m_wb.delete(k); end
      if (bus.ID_Issue && !e_stall && !bus.Stall_In && !bus.Flush && dst != 0) begin
        m_dst.push_back(dst);
        m_wb.push_back(m_t + lat);
      end
      m_t++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ID_Rs = 0; bus.ID_Rt = 0; bus.ID_NeedRs = 0; bus.ID_NeedRt = 0;
    bus.ID_Issue = 0; bus.ID_IssueDst = 0; bus.ID_IssueLat = 0;
    bus.Stall_In = 0; bus.Flush = 0;
  endtask

  task automatic issue(input int d, input int l);
    bus.ID_Issue = 1; bus.ID_IssueDst = RW'(d); bus.ID_IssueLat = LW'(l);
  endtask

  initial begin
    idle();
    repeat (3) cyc();
    rst = 0;

    // Single op dst=8 lat=3: stall twice, then forward on the writeback cycle.
    cyc(); issue(8, 3);
    #1 chk("a_issue_ok", {31'b0, bus.ID_Stall}, 0);
    cyc(); idle(); bus.ID_Rs = 8; bus.ID_NeedRs = 1;
    #1 chk("a_stall_c1", {31'b0, bus.ID_Stall}, 1);
    chk("a_pend_c1", {29'b0, bus.Pending_Count}, 1);
    cyc(); #1 chk("a_stall_c2", {31'b0, bus.ID_Stall}, 1);
    cyc(); #1 chk("a_stall_c3", {31'b0, bus.ID_Stall}, 0);
    chk("a_fwd_c3", {31'b0, bus.ID_RsFwd}, 1);
    chk("a_wbv_c3", {31'b0, bus.WB_Valid}, 1);
    chk("a_wbdst_c3", {27'b0, bus.WB_Dst}, 8);
    chk("a_pend_c3", {29'b0, bus.Pending_Count}, 1);
    cyc(); idle();
    #1 chk("a_wbv_c4", {31'b0, bus.WB_Valid}, 0);
    chk("a_pend_c4", {29'b0, bus.Pending_Count}, 0);

    // Writeback-port collision: lat=3 clashes with the lat=4 op, lat=2 fits.
    cyc(); issue(5, 4);
    cyc(); issue(6, 3);
    #1 chk("b_clash", {31'b0, bus.ID_Stall}, 1);
    bus.ID_IssueLat = 2;
    #1 chk("b_noclash", {31'b0, bus.ID_Stall}, 0);
    cyc(); idle();
    cyc(); #1 chk("b_wbdst_c3", {27'b0, bus.WB_Dst}, 6);
    chk("b_wbv_c3", {31'b0, bus.WB_Valid}, 1);
    cyc(); #1 chk("b_wbdst_c4", {27'b0, bus.WB_Dst}, 5);
    cyc(); #1 chk("b_pend_c5", {29'b0, bus.Pending_Count}, 0);

    // WAW, dst=0 and full table.
    for (int d = 1; d <= 3; d++) begin cyc(); idle(); issue(d, 15); end
    cyc(); idle(); issue(2, 15);
    #1 chk("c_waw", {31'b0, bus.ID_Stall}, 1);
    issue(0, 5);
    #1 chk("c_dst0", {31'b0, bus.ID_Stall}, 0);
    cyc(); idle();
    #1 chk("c_pend3", {29'b0, bus.Pending_Count}, 3);
    issue(4, 15);
    cyc(); issue(9, 3);
    #1 chk("c_full", {31'b0, bus.ID_Stall}, 1);
    chk("c_pend4", {29'b0, bus.Pending_Count}, 4);
    cyc(); idle();
    repeat (16) cyc();
    chk("c_drained", {29'b0, bus.Pending_Count}, 0);

    // Stall counting and asynchronous reset with two ops in flight.
    rst = 1; cyc(); rst = 0;
    cyc(); issue(11, 12);
    cyc(); issue(10, 9);
    #1 chk("e_issue2", {31'b0, bus.ID_Stall}, 0);
    cyc(); idle(); bus.ID_Rs = 10; bus.ID_NeedRs = 1;
    repeat (6) cyc();
    cyc(); bus.ID_NeedRs = 0;
`ifdef HAZARD_PERF_EN
    #1 chk("e_stallcnt7", bus.Stall_Count, 7);
`else
    #1 chk("e_stallcnt0", bus.Stall_Count, 0);
`endif
    chk("e_pend2", {29'b0, bus.Pending_Count}, 2);
    bus.ID_NeedRs = 1;
    #1 rst = 1;
    #1 chk("e_rst_stall", {31'b0, bus.ID_Stall}, 0);
    chk("e_rst_pend", {29'b0, bus.Pending_Count}, 0);
    chk("e_rst_wbv", {31'b0, bus.WB_Valid}, 0);
    chk("e_rst_cnt", bus.Stall_Count, 0);
    cyc(); cyc(); rst = 0; idle();
    repeat (15) cyc();

    // Random traffic against the model.
    repeat (600) begin
      cyc();
      bus.ID_Rs       = RW'($urandom_range(0, 7));
      bus.ID_Rt       = RW'($urandom_range(0, 7));
      bus.ID_NeedRs   = ($urandom_range(0, 1) == 1);
      bus.ID_NeedRt   = ($urandom_range(0, 1) == 1);
      bus.ID_Issue    = ($urandom_range(0, 9) < 4);
      bus.ID_IssueDst = RW'($urandom_range(0, 7));
      bus.ID_IssueLat = LW'($urandom_range(0, 15));
      bus.Stall_In    = ($urandom_range(0, 7) == 0);
      bus.Flush       = ($urandom_range(0, 7) == 0);
    end
    cyc(); idle();
    repeat (20) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_WIDTH, default 5, register specifier width.
REQ-002 Parameter LAT_WIDTH, default 4, latency field width (latency 1..2^LAT_WIDTH-1).
REQ-003 Parameter MAX_PENDING, default 4, number of outstanding long-latency ops tracked.
REQ-004 clock  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 ID_Rs, ID_Rt  in  REG_WIDTH each  source specifiers of the instruction in ID.
REQ-007 ID_NeedRs, ID_NeedRt  in  1 each  instruction requires that operand in ID.
REQ-008 ID_Issue  in  1  ID instruction is a long-latency (mul/div class) op.
REQ-009 ID_IssueDst  in  REG_WIDTH  its destination; ID_IssueLat  in  LAT_WIDTH  its latency.
REQ-010 Stall_In  in  1  stall from downstream/other hazard logic; Flush  in  1  squash ID instruction.
REQ-011 ID_Stall  out  1  scoreboard stall request for ID and earlier stages.
REQ-012 ID_RsFwd, ID_RtFwd  out  1 each  select writeback bus for that operand this cycle.
REQ-013 WB_Valid  out  1; WB_Dst  out  REG_WIDTH  long-op writeback slot this cycle.
REQ-014 Pending_Count  out  $clog2(MAX_PENDING+1)  number of valid entries.
REQ-015 Stall_Count  out  32  stall-cycle counter (see Configuration).

Function
REQ-016 Table of MAX_PENDING entries, each {valid, dst, count}; match = valid & dst==specifier & specifier!=0.
REQ-017 Every cycle each valid entry with count>1 decrements by 1, independent of Stall_In/ID_Stall.
REQ-018 Entry with count==1 drives WB_Valid=1, WB_Dst=dst that cycle and becomes invalid at the next edge.
REQ-019 At most one entry has count==1 per cycle; guaranteed by REQ-022.
REQ-020 Operand stall: ID_Stall=1 if NeedRs & Rs matches an entry with count>1; same for Rt.
REQ-021 Operand forward: ID_RsFwd=1 if Rs matches an entry with count==1 (no stall for that operand); same for Rt; else 0.
REQ-022 Issue stall (when ID_Issue=1): ID_Stall=1 if all entries valid, or IssueDst (nonzero) matches any valid entry (WAW), or any valid entry has count==L+1 where L is effective latency (writeback-port collision).
REQ-023 Effective latency L = ID_IssueLat, with 0 treated as 1.
REQ-024 Issue accepted iff ID_Issue & ~ID_Stall & ~Stall_In & ~Flush; accepted op allocates the lowest-index entry free at this edge: valid=1, dst=IssueDst, count=L; writeback occurs exactly L cycles after acceptance.
REQ-025 Accepted issue with IssueDst==0 allocates nothing.
REQ-026 An entry freed by REQ-018 is not reusable by an issue in the same cycle; full is evaluated on current valid bits.
REQ-027 Flush never affects existing entries; it only blocks allocation.
REQ-028 All outputs combinational from current state and inputs except Pending_Count and Stall_Count (registered-state derived).

Reset
REQ-029 reset asserted clears all valid bits, dst and count immediately, including mid-operation; in-flight writebacks are dropped.
REQ-030 During/after reset: ID_Stall, ID_RsFwd, ID_RtFwd, WB_Valid =0; WB_Dst=0; Pending_Count=0; Stall_Count=0.

Configuration
REQ-031 Macro HAZARD_PERF_EN defined: Stall_Count increments on every edge where ID_Stall=1, saturating at 32'hFFFFFFFF.
REQ-032 Macro HAZARD_PERF_EN undefined: no counter logic; Stall_Count tied to 0; port still present.

Verification
REQ-033 Issue dst=8 lat=3 at cycle 0 -> WB_Valid=1, WB_Dst=8 at cycle 3 only; Pending_Count 1 in cycles 1-3, 0 at cycle 4.
REQ-034 After REQ-033 issue, ID_Rs=8 NeedRs=1 at cycles 1,2 -> ID_Stall=1; at cycle 3 -> ID_Stall=0, ID_RsFwd=1.
REQ-035 Issue dst=5 lat=4 at cycle 0, then issue dst=6 lat=2 at cycle 1 (entry count=4 ==L+1... ) -> no; issue lat=3 at cycle 1 collides (count 4==3+1) -> ID_Stall=1, no allocation; lat=2 accepted, WB_Dst=6 at cycle 3, 5 at cycle 4.
REQ-036 MAX_PENDING=4 entries filled with distinct dst, lat=15 -> fifth issue stalls; issue to dst already pending stalls; dst=0 issue never stalls for WAW and allocates nothing.
REQ-037 Reset asserted asynchronously mid-countdown with 2 entries valid -> all outputs 0 before next edge; no WB_Valid afterwards; with HAZARD_PERF_EN, 7 stall cycles -> Stall_Count=7, cleared by reset.
